weight_stream_loader: RTL
=========================

Name: weight_stream_loader

Overview:
- Writer/reader pair for a parameter buffer; the write-side counterpart to the ROM-backed weight sources.
- Accepts a valid/ready stream of weight beats and writes DEPTH beats into an internal RAM (load phase).
- Then streams the stored tensor out continuously and cyclically on a valid/ready interface (serve phase), with correct backpressure across the 2-cycle RAM read latency.
- Sits between the host/DMA weight path and the linear-layer weight ports.

Parameters:
- PRECISION, 16, bit width of one weight element.
- PARALLELISM, 4, elements per beat (in and out).
- DEPTH, 8, beats per tensor (RAM words); must be >= 2.
- ADDR_WIDTH, $clog2(DEPTH)+1, address/counter width.
- FIFO_DEPTH, 4, output buffer entries; must be >= 3.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- reload  input  1  pulse: discard contents, return to load phase.
- data_in  input  PRECISION x [PARALLELISM]  unpacked array, incoming beat.
- data_in_valid  input  1  incoming beat valid.
- data_in_ready  output  1  loader accepts beat.
- data_out  output  PRECISION x [PARALLELISM]  unpacked array, FIFO head beat.
- data_out_valid  output  1  data_out valid.
- data_out_ready  input  1  consumer accepts beat.
- loaded  output  1  high while in SERVE.

Behaviour:
- Reset: state=LOAD, wr_addr=0, rd_addr=0, pipeline stages empty, FIFO empty, loaded=0, data_out_valid=0. data_in_ready=0 while rst=1.
- RAM: DEPTH words x (PRECISION*PARALLELISM) bits. Element j of a beat is stored at bits [PRECISION*j +: PRECISION].
- Reads are 2-stage registered: address captured at cycle c; stage1 valid at c+1; stage2 valid at c+2; entry pushed to FIFO at the end of c+2.
- LOAD state:
  - data_in_ready = !reload.
  - On data_in_valid & data_in_ready: mem[wr_addr] <= data_in; wr_addr++.
  - On the handshake at wr_addr==DEPTH-1: wr_addr<=0 and state<=SERVE, so loaded=1 from the next cycle.
  - data_out_valid=0 throughout LOAD.
- SERVE state:
  - data_in_ready=0.
  - Issue a read when (fifo_count + inflight - pop) < FIFO_DEPTH, where pop = data_out_valid & data_out_ready and inflight = number of valid pipeline stages.
  - On issue, rd_addr++, wrapping DEPTH-1 -> 0.
  - data_out_valid = (fifo_count != 0). data_out is the FIFO head and must hold stable while valid & !ready.
  - The output sequence is beat 0,1,...,DEPTH-1,0,1,... indefinitely, with no gaps or duplicates under any ready pattern.
  - Latency: first SERVE cycle S issues addr 0; data_out_valid=1 first in cycle S+3.
  - With data_out_ready held at 1, throughput is 1 beat/cycle from S+3 onward.
  - FIFO never overflows; a simultaneous push and pop leaves fifo_count unchanged.
- reload (any state), taking effect at the clock edge:
  - state<=LOAD, wr_addr<=0, rd_addr<=0, pipeline and FIFO flushed, loaded<=0.
  - No handshake occurs in the reload cycle on either side: data_in_ready=0, and any data_out pop is ignored.
  - A reload mid-load discards the partial load; RAM contents are simply overwritten by the next load.
- Reset mid-operation behaves as reload; it has priority over all else.
- Arithmetic: counters are ADDR_WIDTH wide and compare against DEPTH-1 explicitly; no reliance on natural overflow.

Test Plan:
- Basic load/serve (DEPTH=8, PARALLELISM=4, PRECISION=16):
  - Stimulus: load beats k=0..7 with element j = 16*k+j, valid back-to-back; hold data_out_ready=1.
  - Required: loaded rises the cycle after the 8th handshake; data_out_valid rises 3 cycles later; output beats run 0..7,0..7 (element j of beat k = 16*k+j) on consecutive cycles for at least 24 beats.
- Bubbly input:
  - Stimulus: data_in_valid toggles 1/0.
  - Required: exactly 8 handshakes are accepted; data_in_ready=0 after the 8th; RAM contents match the load order.
- Backpressure:
  - Stimulus: data_out_ready random at 30% during serve.
  - Required: no lost or duplicated beats; data_out is stable while valid & !ready; fifo_count stays <= 4; the sequence wraps 7->0 correctly.
- Stall then release:
  - Stimulus: data_out_ready=0 for 20 cycles after loaded, then 1.
  - Required: at most 4 beats are buffered; release yields beats 0,1,2,3,4... at 1 beat/cycle.
- Reload mid-serve:
  - Stimulus: after 5 output beats, pulse reload, then load new data (element = 0x100+16*k+j).
  - Required: loaded=0 and data_out_valid=0 the cycle after reload; the new stream starts at new beat 0 with no stale beats.
- Reload mid-load and reset:
  - Stimulus: pulse reload after 3 beats, then load 8 fresh beats; separately, assert rst during serve.
  - Required: the output shows only the fresh beats 0..7; after rst, data_out_valid=0, loaded=0, and data_in_ready=1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/weight_stream_loader.sv
`default_nettype none
// ============================================================================
// Module  : weight_stream_loader
// Loads DEPTH weight beats into RAM, then serves them cyclically via a FIFO.
// Revision: 1.0
// ============================================================================
module weight_stream_loader #(
  parameter int PRECISION   = 16,
  parameter int PARALLELISM = 4,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reload,
  input  logic [PRECISION-1:0] data_in [PARALLELISM],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [PRECISION-1:0] data_out [PARALLELISM],
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 loaded
);

  localparam int c_WORD_W  = PRECISION * PARALLELISM;
  localparam int c_RAM_AW  = $clog2(DEPTH);
  localparam int c_FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 2) + 1;
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [c_FIFO_AW-1:0]  c_FIFO_LAST = c_FIFO_AW'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {LOAD = 1'b0, SERVE = 1'b1} state_t;

  state_t                  r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_wr_addr, r_rd_addr;
  logic [c_WORD_W-1:0]     r_mem [DEPTH];
  logic [c_WORD_W-1:0]     w_in_word;

  logic                    r_s1_valid, r_s2_valid;
  logic [c_RAM_AW-1:0]     r_s1_addr;
  logic [c_WORD_W-1:0]     r_s2_data;

  logic [c_WORD_W-1:0]     r_fifo_mem [FIFO_DEPTH];
  logic [c_FIFO_AW-1:0]    r_fifo_wr_ptr, r_fifo_rd_ptr;
  logic [c_CNT_W-1:0]      r_fifo_count;

  logic                    w_flush, w_in_fire, w_pop, w_push, w_issue;
  logic [c_CNT_W-1:0]      w_occ;

  generate
    for (genvar j = 0; j < PARALLELISM; j++) begin : g_lane
      assign w_in_word[PRECISION*j +: PRECISION] = data_in[j];
      assign data_out[j] = r_fifo_mem[r_fifo_rd_ptr][PRECISION*j +: PRECISION];
    end
  endgenerate

  assign w_flush        = rst | reload;
  assign data_in_ready  = (r_state == LOAD) & ~w_flush;
  assign w_in_fire      = data_in_valid & data_in_ready;
  assign data_out_valid = (r_fifo_count != '0);
  assign w_pop          = data_out_valid & data_out_ready & ~w_flush;
  assign w_push         = r_s2_valid;
  assign loaded         = (r_state == SERVE);

  // Reads in flight are reserved against FIFO space so a push never overflows.
  assign w_occ   = r_fifo_count + c_CNT_W'(r_s1_valid) + c_CNT_W'(r_s2_valid);
  assign w_issue = (r_state == SERVE) & ~w_flush &
                   (w_occ < (c_CNT_W'(FIFO_DEPTH) + c_CNT_W'(w_pop)));

  always_ff @(posedge clk) begin
    if (w_flush) r_state <= LOAD;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD:    if (w_in_fire && (r_wr_addr == c_LAST_ADDR)) w_state_next = SERVE;
      SERVE:   w_state_next = SERVE;
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_addr <= '0;
    end else if (w_in_fire) begin
      r_wr_addr <= (r_wr_addr == c_LAST_ADDR) ? '0 : r_wr_addr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_rd_addr <= '0;
    end else if (w_issue) begin
      r_rd_addr <= (r_rd_addr == c_LAST_ADDR) ? '0 : r_rd_addr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) r_mem[r_wr_addr[c_RAM_AW-1:0]] <= w_in_word;
  end

  always_ff @(posedge clk) begin
    r_s1_addr <= r_rd_addr[c_RAM_AW-1:0];
    r_s2_data <= r_mem[r_s1_addr];
    if (w_flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_issue;
      r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_flush) r_fifo_mem[r_fifo_wr_ptr] <= r_s2_data;
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_fifo_wr_ptr <= '0;
      r_fifo_rd_ptr <= '0;
      r_fifo_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_wr_ptr <= (r_fifo_wr_ptr == c_FIFO_LAST) ? '0 : r_fifo_wr_ptr + c_FIFO_AW'(1);
      end
      if (w_pop) begin
        r_fifo_rd_ptr <= (r_fifo_rd_ptr == c_FIFO_LAST) ? '0 : r_fifo_rd_ptr + c_FIFO_AW'(1);
      end
      if (w_push && !w_pop)      r_fifo_count <= r_fifo_count + c_CNT_W'(1);
      else if (!w_push && w_pop) r_fifo_count <= r_fifo_count - c_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
